// File: rtl/hls_perf_mon_pkg.sv
// hls_perf_mon_pkg
// Shared types and constants for the HLS performance monitor.
//   mon_state_t   per-channel handshake tracker state
//   rd_sel_t      statistic selector on the read port
//   STATUS_*      bit positions inside the status word
//   pack_status   builds the 4-bit status word for one channel
package hls_perf_mon_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } mon_state_t;

  typedef enum logic [2:0] {
    RD_TXN       = 3'd0,
    RD_LAST_LAT  = 3'd1,
    RD_MIN_LAT   = 3'd2,
    RD_MAX_LAT   = 3'd3,
    RD_BUSY_CYC  = 3'd4,
    RD_STALL_CYC = 3'd5,
    RD_ITER_CNT  = 3'd6,
    RD_STATUS    = 3'd7
  } rd_sel_t;

  localparam int NUM_STATS        = 8;
  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_STATE_W   = 2;
  localparam int STATUS_OVF       = 2;
  localparam int STATUS_READY     = 3;
  localparam int STATUS_W         = 4;

  function automatic logic [STATUS_W-1:0] pack_status(input mon_state_t st,
                                                      input logic       ovf,
                                                      input logic       rdy);
    logic [STATUS_W-1:0] s;
    s = '0;
    s[STATUS_STATE_LSB +: STATUS_STATE_W] = st;
    s[STATUS_OVF]   = ovf;
    s[STATUS_READY] = rdy;
    return s;
  endfunction

endpackage

// File: rtl/hls_perf_monitor_if.sv
// hls_perf_monitor_if
// Bundles the observed HLS handshakes, the control inputs and the
// statistic read port of hls_perf_monitor.
//   master : the observed design / host side (drives handshakes and reads)
//   slave  : the monitor side
// Signals: ap_start, ap_ready, ap_done, ap_continue, iter_end, iter_stall,
// clear (all NUM_CH wide), freeze, rd_en, rd_ch, rd_sel, rd_valid,
// rd_data (CNT_W), busy (NUM_CH).
interface hls_perf_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic [NUM_CH-1:0] iter_end;
  logic [NUM_CH-1:0] iter_stall;
  logic              freeze;
  logic [NUM_CH-1:0] clear;
  logic              rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [2:0]        rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] busy;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, iter_end, iter_stall,
    output freeze, clear, rd_en, rd_ch, rd_sel,
    input  rd_valid, rd_data, busy
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, iter_end, iter_stall,
    input  freeze, clear, rd_en, rd_ch, rd_sel,
    output rd_valid, rd_data, busy
  );

endinterface

// File: rtl/hls_perf_mon_channel.sv
// hls_perf_mon_channel
// Tracks one HLS block handshake and its pipelined-loop strobes and keeps
// saturating statistics for it.
//   clock, reset        clock and synchronous active-high reset
//   freeze              hold FSM and counters
//   clear               zero the statistics (FSM and in-flight latency kept)
//   ap_*                observed block-level handshake
//   iter_end/iter_stall loop iteration strobe / pipeline blocked
//   busy                FSM is not IDLE
//   stats               post-update value of every statistic, indexed by rd_sel_t
module hls_perf_mon_channel
  import hls_perf_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             freeze,
  input  logic                             clear,
  input  logic                             ap_start,
  input  logic                             ap_ready,
  input  logic                             ap_done,
  input  logic                             ap_continue,
  input  logic                             iter_end,
  input  logic                             iter_stall,
  output logic                             busy,
  output logic [NUM_STATS-1:0][CNT_W-1:0]  stats
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mon_state_t state, state_nxt;

  logic [CNT_W-1:0] lat_cur,   lat_nxt;
  logic [CNT_W-1:0] txn_cnt,   txn_nxt;
  logic [CNT_W-1:0] last_lat,  last_nxt;
  logic [CNT_W-1:0] min_lat,   min_nxt;
  logic [CNT_W-1:0] max_lat,   max_nxt;
  logic [CNT_W-1:0] busy_cyc,  busy_nxt;
  logic [CNT_W-1:0] stall_cyc, stall_nxt;
  logic [CNT_W-1:0] iter_cnt,  iter_nxt;
  logic             ovf,       ovf_nxt;
  logic             ready_q,   ready_nxt;

  logic lat_start, lat_inc, busy_inc, stall_inc, iter_inc, done_evt, sat_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Handshake FSM: decides the next state and which counters advance this
  // cycle. Nothing advances while frozen.
  always_comb begin
    state_nxt = state;
    lat_start = 1'b0;
    lat_inc   = 1'b0;
    busy_inc  = 1'b0;
    stall_inc = 1'b0;
    iter_inc  = 1'b0;
    done_evt  = 1'b0;
    if (!freeze) begin
      iter_inc = iter_end;
      case (state)
        IDLE: begin
          if (ap_start) begin
            lat_start = 1'b1;
            busy_inc  = 1'b1;
            if (ap_done) begin
              done_evt  = 1'b1;
              state_nxt = ap_continue ? IDLE : DONE_WAIT;
            end else begin
              state_nxt = BUSY;
            end
          end
        end
        BUSY: begin
          lat_inc   = 1'b1;
          busy_inc  = 1'b1;
          stall_inc = iter_stall;
          if (ap_done) begin
            done_evt  = 1'b1;
            state_nxt = ap_continue ? IDLE : DONE_WAIT;
          end
        end
        DONE_WAIT: begin
          if (ap_continue) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Statistic update. Clear is applied last so it overrides any update in
  // the same cycle, but lat_cur is left alone so an in-flight transaction
  // still completes with its full latency.
  always_comb begin
    lat_nxt = lat_cur;
    if (lat_start)    lat_nxt = CNT_ONE;
    else if (lat_inc) lat_nxt = sat_inc(lat_cur);

    busy_nxt  = busy_inc  ? sat_inc(busy_cyc)  : busy_cyc;
    stall_nxt = stall_inc ? sat_inc(stall_cyc) : stall_cyc;
    iter_nxt  = iter_inc  ? sat_inc(iter_cnt)  : iter_cnt;

    txn_nxt  = txn_cnt;
    last_nxt = last_lat;
    min_nxt  = min_lat;
    max_nxt  = max_lat;
    if (done_evt) begin
      txn_nxt  = sat_inc(txn_cnt);
      last_nxt = lat_nxt;
      if (lat_nxt < min_lat) min_nxt = lat_nxt;
      if (lat_nxt > max_lat) max_nxt = lat_nxt;
    end

    sat_hit = (lat_inc   && (lat_cur   == CNT_MAX)) ||
              (busy_inc  && (busy_cyc  == CNT_MAX)) ||
              (stall_inc && (stall_cyc == CNT_MAX)) ||
              (iter_inc  && (iter_cnt  == CNT_MAX)) ||
              (done_evt  && (txn_cnt   == CNT_MAX));
    ovf_nxt   = ovf | sat_hit;
    ready_nxt = freeze ? ready_q : ap_ready;

    if (clear && !freeze) begin
      txn_nxt   = '0;
      last_nxt  = '0;
      min_nxt   = '1;
      max_nxt   = '0;
      busy_nxt  = '0;
      stall_nxt = '0;
      iter_nxt  = '0;
      ovf_nxt   = 1'b0;
    end
  end

  // State and statistic registers; min_lat resets to all-ones ("no sample").
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      lat_cur   <= '0;
      txn_cnt   <= '0;
      last_lat  <= '0;
      min_lat   <= '1;
      max_lat   <= '0;
      busy_cyc  <= '0;
      stall_cyc <= '0;
      iter_cnt  <= '0;
      ovf       <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      lat_cur   <= lat_nxt;
      txn_cnt   <= txn_nxt;
      last_lat  <= last_nxt;
      min_lat   <= min_nxt;
      max_lat   <= max_nxt;
      busy_cyc  <= busy_nxt;
      stall_cyc <= stall_nxt;
      iter_cnt  <= iter_nxt;
      ovf       <= ovf_nxt;
      ready_q   <= ready_nxt;
    end
  end

  assign busy = (state != IDLE);

  // Read view: values as they stand after this cycle's update.
  always_comb begin
    stats               = '0;
    stats[RD_TXN]       = txn_nxt;
    stats[RD_LAST_LAT]  = last_nxt;
    stats[RD_MIN_LAT]   = min_nxt;
    stats[RD_MAX_LAT]   = max_nxt;
    stats[RD_BUSY_CYC]  = busy_nxt;
    stats[RD_STALL_CYC] = stall_nxt;
    stats[RD_ITER_CNT]  = iter_nxt;
    stats[RD_STATUS]    = CNT_W'(pack_status(state_nxt, ovf_nxt, ready_nxt));
  end

endmodule

// File: rtl/hls_perf_monitor.sv
// hls_perf_monitor
// Per-channel performance statistics for HLS block handshakes and pipelined
// loops, readable through a one-cycle-latency register port.
//   clock, reset  clock and synchronous active-high reset
//   mon           hls_perf_monitor_if slave: handshakes, freeze, clear,
//                 rd_en/rd_ch/rd_sel -> rd_valid/rd_data, busy
module hls_perf_monitor
  import hls_perf_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  hls_perf_monitor_if.slave   mon
);

  logic [NUM_STATS-1:0][CNT_W-1:0] ch_stats [NUM_CH];
  logic [NUM_CH-1:0]               busy_vec;
  logic [CNT_W-1:0]                rd_mux;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hls_perf_mon_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .freeze      (mon.freeze),
      .clear       (mon.clear[g]),
      .ap_start    (mon.ap_start[g]),
      .ap_ready    (mon.ap_ready[g]),
      .ap_done     (mon.ap_done[g]),
      .ap_continue (mon.ap_continue[g]),
      .iter_end    (mon.iter_end[g]),
      .iter_stall  (mon.iter_stall[g]),
      .busy        (busy_vec[g]),
      .stats       (ch_stats[g])
    );
  end

  assign mon.busy = busy_vec;

  // Channel select; a channel number beyond NUM_CH matches nothing and reads 0.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(mon.rd_ch) == c) rd_mux = ch_stats[c][mon.rd_sel];
    end
  end

  // Registered read port; rd_data keeps its value between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      mon.rd_valid <= 1'b0;
      mon.rd_data  <= '0;
    end else begin
      mon.rd_valid <= mon.rd_en;
      if (mon.rd_en) mon.rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_hls_perf_monitor.sv
// tb_hls_perf_monitor
// Directed bench: a 4-channel 32-bit monitor (busA/dutA, wide channel select
// so out-of-range channels are reachable) and a 1-channel 4-bit monitor
// (busB/dutB) for saturation.
module tb_hls_perf_monitor;

  logic clock;
  logic reset;

  int errors = 0;
  int checks = 0;

  hls_perf_monitor_if #(.NUM_CH(4), .CNT_W(32), .CH_W(3)) busA ();
  hls_perf_monitor_if #(.NUM_CH(1), .CNT_W(4),  .CH_W(1)) busB ();

  hls_perf_monitor #(.NUM_CH(4), .CNT_W(32), .CH_W(3)) dutA (
    .clock (clock),
    .reset (reset),
    .mon   (busA)
  );

  hls_perf_monitor #(.NUM_CH(1), .CNT_W(4), .CH_W(1)) dutB (
    .clock (clock),
    .reset (reset),
    .mon   (busB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          st;
    int          dn;
    int          ie;
    int          is;
    int          re;
    int          rs;
    int          expBusy;
    int          expValid;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    busA.ap_start[0]   = 1'(v.st);
    busA.ap_done[0]    = 1'(v.dn);
    busA.iter_end[0]   = 1'(v.ie);
    busA.iter_stall[0] = 1'(v.is);
    busA.rd_en         = 1'(v.re);
    busA.rd_ch         = 3'd0;
    busA.rd_sel        = 3'(v.rs);
    tick();
  endtask

  task automatic readA(input int ch, input int sel, input logic [31:0] exp, input string name);
    busA.rd_en  = 1'b1;
    busA.rd_ch  = 3'(ch);
    busA.rd_sel = 3'(sel);
    tick();
    checkOutput({name, "_valid"}, 32'(busA.rd_valid), 32'd1);
    checkOutput(name, busA.rd_data, exp);
    busA.rd_en = 1'b0;
  endtask

  task automatic readB(input int ch, input int sel, input logic [31:0] exp, input string name);
    busB.rd_en  = 1'b1;
    busB.rd_ch  = 1'(ch);
    busB.rd_sel = 3'(sel);
    tick();
    checkOutput({name, "_valid"}, 32'(busB.rd_valid), 32'd1);
    checkOutput(name, 32'(busB.rd_data), exp);
    busB.rd_en = 1'b0;
  endtask

  // One transaction of 'lat' cycles on channel ch of dutA, optional clear at
  // step clrAt (1-based, 0 = none), followed by one idle cycle.
  task automatic runTxn(input int ch, input int lat, input int clrAt);
    for (int k = 1; k <= lat; k++) begin
      busA.ap_start[ch] = (k == 1);
      busA.ap_done[ch]  = (k == lat);
      busA.clear[ch]    = (k == clrAt);
      tick();
    end
    busA.ap_start[ch] = 1'b0;
    busA.ap_done[ch]  = 1'b0;
    busA.clear[ch]    = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 1, 2, 0, 1, 32'hFFFF_FFFF};
    vecs[1]  = '{0, 0, 0, 0, 1, 7, 0, 1, 0};
    vecs[2]  = '{1, 0, 0, 0, 1, 4, 1, 1, 1};
    vecs[3]  = '{0, 0, 1, 0, 1, 7, 1, 1, 1};
    vecs[4]  = '{0, 0, 1, 1, 0, 0, 1, 0, 1};
    vecs[5]  = '{0, 0, 1, 0, 1, 6, 1, 1, 3};
    vecs[6]  = '{0, 1, 1, 0, 1, 1, 0, 1, 5};
    vecs[7]  = '{0, 0, 0, 0, 1, 0, 0, 1, 1};
    vecs[8]  = '{0, 0, 0, 0, 1, 2, 0, 1, 5};
    vecs[9]  = '{0, 0, 0, 0, 1, 3, 0, 1, 5};
    vecs[10] = '{0, 0, 0, 0, 1, 4, 0, 1, 5};
    vecs[11] = '{0, 0, 0, 1, 1, 5, 0, 1, 1};
    vecs[12] = '{0, 0, 1, 1, 1, 6, 0, 1, 5};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 5};
    vecs[14] = '{0, 0, 0, 0, 1, 5, 0, 1, 1};

    reset = 1'b1;
    busA.ap_start = '0; busA.ap_ready = '0; busA.ap_done = '0; busA.ap_continue = '0;
    busA.iter_end = '0; busA.iter_stall = '0; busA.freeze = 1'b0; busA.clear = '0;
    busA.rd_en = 1'b0; busA.rd_ch = '0; busA.rd_sel = '0;
    busB.ap_start = '0; busB.ap_ready = '0; busB.ap_done = '0; busB.ap_continue = '0;
    busB.iter_end = '0; busB.iter_stall = '0; busB.freeze = 1'b0; busB.clear = '0;
    busB.rd_en = 1'b0; busB.rd_ch = '0; busB.rd_sel = '0;
    tick(); tick(); tick();
    checkOutput("reset_rd_valid", 32'(busA.rd_valid), 32'd0);
    checkOutput("reset_rd_data", busA.rd_data, 32'd0);
    checkOutput("reset_busy", 32'(busA.busy), 32'd0);
    reset = 1'b0;

    // Single transaction and loop strobes on ch0, cycle by cycle.
    busA.ap_continue = 4'hF;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_busy", i), 32'(busA.busy[0]), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d_valid", i), 32'(busA.rd_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_data", i), busA.rd_data, vecs[i].expData);
    end
    busA.ap_start[0] = 1'b0; busA.ap_done[0] = 1'b0;
    busA.iter_end[0] = 1'b0; busA.iter_stall[0] = 1'b0; busA.rd_en = 1'b0;

    // Dataflow hold-off on ch2.
    busA.ap_start[2] = 1'b1; tick();
    busA.ap_start[2] = 1'b0; tick();
    tick();
    busA.ap_done[2] = 1'b1; busA.ap_continue[2] = 1'b0;
    readA(2, 1, 4, "hold_last_lat");
    busA.ap_done[2] = 1'b0;
    readA(2, 7, 2, "hold_status_dw");
    checkOutput("hold_busy", 32'(busA.busy[2]), 32'd1);
    busA.ap_start[2] = 1'b1;
    readA(2, 0, 1, "hold_txn_not_counted");
    readA(2, 7, 2, "hold_status_dw2");
    busA.ap_continue[2] = 1'b1;
    readA(2, 4, 4, "hold_busy_cyc_release");
    readA(2, 4, 5, "hold_busy_cyc_restart");
    busA.ap_start[2] = 1'b0; busA.ap_done[2] = 1'b1;
    readA(2, 1, 2, "hold_last_lat2");
    busA.ap_done[2] = 1'b0;
    readA(2, 0, 2, "hold_txn");
    readA(2, 3, 4, "hold_max");
    readA(2, 2, 2, "hold_min");

    // Loop statistics on ch1: idle stalls ignored, BUSY stalls counted.
    busA.iter_stall[1] = 1'b1; tick(); tick();
    busA.iter_stall[1] = 1'b0;
    busA.ap_start[1] = 1'b1; tick();
    busA.ap_start[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      busA.iter_end[1]   = (k <= 8);
      busA.iter_stall[1] = (k >= 2 && k <= 4);
      busA.ap_done[1]    = (k == 10);
      tick();
    end
    busA.iter_end[1] = 1'b0; busA.iter_stall[1] = 1'b0; busA.ap_done[1] = 1'b0;
    readA(1, 6, 8, "loop_iter_cnt");
    readA(1, 5, 3, "loop_stall_cyc");
    readA(1, 4, 11, "loop_busy_cyc");
    readA(1, 1, 11, "loop_last_lat");

    // Min/max, clear racing a completion, clear during a transaction.
    busA.clear[1] = 1'b1; tick(); busA.clear[1] = 1'b0;
    readA(1, 2, 32'hFFFF_FFFF, "clr_min_empty");
    readA(1, 6, 0, "clr_iter");
    runTxn(1, 7, 0);
    runTxn(1, 3, 0);
    runTxn(1, 9, 0);
    readA(1, 2, 3, "mm_min");
    readA(1, 3, 9, "mm_max");
    readA(1, 0, 3, "mm_txn");
    readA(1, 4, 19, "mm_busy_cyc");
    runTxn(1, 4, 4);
    readA(1, 0, 0, "clrdone_txn");
    readA(1, 1, 0, "clrdone_last");
    readA(1, 2, 32'hFFFF_FFFF, "clrdone_min");
    readA(1, 3, 0, "clrdone_max");
    readA(1, 4, 0, "clrdone_busy");
    runTxn(1, 2, 0);
    readA(1, 0, 1, "after_txn");
    readA(1, 2, 2, "after_min");
    readA(1, 3, 2, "after_max");
    runTxn(1, 5, 3);
    readA(1, 0, 1, "midclr_txn");
    readA(1, 1, 5, "midclr_last");
    readA(1, 4, 2, "midclr_busy");

    // Overlapping ch0/ch3 with a 5-cycle freeze.
    busA.ap_start[0] = 1'b1; tick(); busA.ap_start[0] = 1'b0;
    busA.ap_start[3] = 1'b1; tick(); busA.ap_start[3] = 1'b0;
    checkOutput("mc_busy_vec", 32'(busA.busy), 32'h9);
    busA.freeze = 1'b1;
    busA.iter_end[3] = 1'b1; tick(); busA.iter_end[3] = 1'b0;
    readA(0, 7, 1, "frz_status");
    checkOutput("frz_busy_vec", 32'(busA.busy), 32'h9);
    tick(); tick(); tick();
    busA.freeze = 1'b0;
    tick();
    busA.ap_done[0] = 1'b1; tick(); busA.ap_done[0] = 1'b0;
    busA.ap_done[3] = 1'b1; tick(); busA.ap_done[3] = 1'b0;
    tick();
    readA(0, 1, 4, "frz_ch0_last");
    readA(0, 0, 2, "frz_ch0_txn");
    readA(0, 2, 4, "frz_ch0_min");
    readA(0, 3, 5, "frz_ch0_max");
    readA(0, 4, 9, "frz_ch0_busy");
    readA(3, 1, 4, "frz_ch3_last");
    readA(3, 6, 0, "frz_ch3_iter_lost");
    readA(3, 4, 4, "frz_ch3_busy");
    readA(5, 0, 0, "oob_channel");
    tick();
    checkOutput("rd_valid_idle", 32'(busA.rd_valid), 32'd0);
    busA.ap_ready[2] = 1'b1;
    readA(2, 7, 8, "status_ready");
    busA.ap_ready[2] = 1'b0;

    // Saturation on the 4-bit instance.
    busB.ap_continue[0] = 1'b1;
    busB.ap_start[0] = 1'b1; tick(); busB.ap_start[0] = 1'b0;
    for (int k = 0; k < 19; k++) tick();
    busB.ap_done[0] = 1'b1; tick(); busB.ap_done[0] = 1'b0;
    tick();
    readB(0, 4, 15, "sat_busy_cyc");
    readB(0, 1, 15, "sat_last_lat");
    readB(0, 7, 4, "sat_status_ovf");
    readB(1, 0, 0, "sat_oob_channel");
    busB.clear[0] = 1'b1; tick(); busB.clear[0] = 1'b0;
    readB(0, 7, 0, "sat_status_cleared");
    readB(0, 4, 0, "sat_busy_cleared");

    // Reset in the middle of a transaction.
    busA.ap_start[2] = 1'b1; tick(); busA.ap_start[2] = 1'b0;
    tick();
    checkOutput("abort_busy_before", 32'(busA.busy[2]), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    checkOutput("abort_busy_after", 32'(busA.busy), 32'd0);
    busA.ap_done[2] = 1'b1; tick(); busA.ap_done[2] = 1'b0;
    readA(2, 0, 0, "abort_txn");
    readA(2, 2, 32'hFFFF_FFFF, "abort_min");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hls_perf_monitor.md
Name: hls_perf_monitor

Overview:
- Synthesizable, parametrised successor to the simulation-only dataflow/loop status dumpers.
- Observes up to NUM_CH HLS block-level handshakes (ap_start/ap_ready/ap_done/ap_continue) plus per-channel pipelined-loop iteration and stall strobes.
- Keeps per-channel saturating statistics: transactions, last/min/max latency, busy, stall and iteration counts.
- Exposes the statistics through a 1-cycle-latency register read port, so the same measurements are available on silicon and in co-simulation.

Parameters:
- NUM_CH, 4, number of monitored module/loop channels (1..16).
- CNT_W, 32, width of every statistic counter.
- CH_W, $clog2(NUM_CH) (min 1), width of the read channel select.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  NUM_CH  per-channel ap_start.
- ap_ready  in  NUM_CH  per-channel ap_ready (status only).
- ap_done  in  NUM_CH  per-channel ap_done.
- ap_continue  in  NUM_CH  per-channel ap_continue; tie 1 for non-dataflow blocks.
- iter_end  in  NUM_CH  1-cycle strobe per completed loop iteration (end state && enable && !block).
- iter_stall  in  NUM_CH  high while the loop pipeline is blocked (subdone asserted).
- freeze  in  1  high: hold all counters and FSMs (drive from finish).
- clear  in  NUM_CH  per-channel synchronous statistics clear.
- rd_en  in  1  read request.
- rd_ch  in  CH_W  channel to read.
- rd_sel  in  3  statistic select, see Behaviour.
- rd_valid  out  1  rd_data valid; one cycle after rd_en.
- rd_data  out  CNT_W  selected statistic.
- busy  out  NUM_CH  channel FSM is not IDLE.

Behaviour:
- Reset: all per-channel FSMs go to IDLE. All counters reset to 0, except min_lat, which resets to all-ones (meaning "no sample"). Overflow flags clear. rd_valid=0, rd_data=0, busy=0.
- Per-channel FSM, states IDLE, BUSY, DONE_WAIT:
  - Transaction start: the first cycle with state==IDLE && ap_start. That cycle increments the latency counter lat_cur to 1.
  - IDLE: start && ap_done && ap_continue in the same cycle gives a latency-1 transaction; the FSM stays IDLE.
  - IDLE: start with !ap_done goes to BUSY.
  - BUSY: lat_cur increments every cycle.
  - BUSY: ap_done && ap_continue goes to IDLE and completes the transaction.
  - BUSY: ap_done && !ap_continue goes to DONE_WAIT and completes the transaction (latency stops at the ap_done cycle).
  - DONE_WAIT: ap_continue goes to IDLE. A new start is accepted only from IDLE, so back-to-back transactions have at least one IDLE cycle.
- Transaction completion, in the same cycle the transaction ends:
  - txn_cnt += 1.
  - last_lat = latency, counted inclusive from the start cycle to the ap_done cycle.
  - min_lat = min(min_lat, latency); max_lat = max(max_lat, latency).
- busy_cyc increments each cycle state is BUSY, and in the start cycle.
- stall_cyc increments each cycle state is BUSY && iter_stall.
- iter_cnt increments on iter_end, in any state.
- Saturation: every counter, including lat_cur, saturates at 2^CNT_W-1 and never wraps. The first saturation of any counter in a channel sets that channel's sticky ovf flag.
- freeze=1: no FSM transition and no counter update. Reads continue to work. Events arriving during freeze are lost by design.
- clear[i] (ignored during freeze):
  - Zeroes txn_cnt, last_lat, max_lat, busy_cyc, stall_cyc, iter_cnt and ovf; sets min_lat to all-ones.
  - Clear wins over a same-cycle update.
  - The FSM state and an in-flight lat_cur are preserved, so the in-flight transaction is still recorded when it completes.
- Read port:
  - rd_en samples rd_ch/rd_sel; the next cycle gives rd_valid=1 and rd_data = value after the current-cycle update.
  - rd_sel encoding: 0 txn_cnt, 1 last_lat, 2 min_lat, 3 max_lat, 4 busy_cyc, 5 stall_cyc, 6 iter_cnt, 7 status.
  - Status layout: bits[1:0] FSM state (0 IDLE, 1 BUSY, 2 DONE_WAIT), bit2 ovf, bit3 ap_ready sampled, remaining bits zero.
  - rd_ch >= NUM_CH returns 0 with rd_valid=1.
  - Without rd_en, rd_valid=0 and rd_data holds its last value.
- Reset asserted mid-transaction aborts the transaction with no statistics recorded.

Decomposition:
- Package hls_perf_mon_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE_WAIT} mon_state_t;
  - typedef enum logic [2:0] rd_sel_t, with the encoding above;
  - STATUS_* bit-index constants.
- Sub-module hls_perf_mon_channel (FSM plus all counters for one channel, CNT_W parameter), instantiated NUM_CH times by a generate loop.
- The top level contains only the instances and the registered read mux.

Test Plan:
- Single transaction: ap_start at cycle 10, ap_done at cycle 14, ap_continue=1 -> txn_cnt=1, last_lat=min_lat=max_lat=5, busy_cyc=5; FSM returns to IDLE at cycle 15.
- Dataflow hold-off: ap_done at cycle 20 with ap_continue=0 until cycle 25 -> status reads DONE_WAIT during cycles 21-25; a start raised at cycle 22 is not counted until the IDLE cycle 26; latency excludes the hold-off.
- Loop stats: 8 iter_end pulses and 3 iter_stall cycles inside BUSY, plus 2 iter_stall cycles in IDLE -> iter_cnt=8, stall_cyc=3.
- Min/max and clear: latencies 7, 3, 9 -> min_lat=3, max_lat=9; clear in the same cycle as a 4th completion -> all stats 0, min_lat=all-ones; the next transaction then records correctly.
- Saturation with CNT_W=4: a BUSY phase of 20 cycles -> busy_cyc=15, last_lat=15, status ovf=1; a subsequent clear drops ovf to 0.
- Multi-channel and freeze with NUM_CH=4: overlapping transactions on ch0/ch3; freeze held for 5 cycles mid-transaction -> latency excludes the frozen cycles; a read of rd_ch=5 returns 0 with rd_valid=1 one cycle after rd_en.
